// File: rtl/dcache_bus_pkg.sv
// rtl/dcache_bus_pkg.sv - shared request types, AXI constants and FSM states for the dcache bridge
package dcache_bus_pkg;

  typedef enum logic [2:0] {
    REQ_BYTE = 3'b000,
    REQ_HALF = 3'b001,
    REQ_WORD = 3'b010,
    REQ_LINE = 3'b100
  } req_type_e;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} w_state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_1B    = 3'd0;
  localparam logic [2:0] SIZE_2B    = 3'd1;
  localparam logic [2:0] SIZE_4B    = 3'd2;
  localparam int         LINE_BEATS = 4;
  localparam logic [7:0] LINE_LEN   = 8'(LINE_BEATS - 1);

  function automatic logic is_line(input logic [2:0] t);
    return t == REQ_LINE;
  endfunction

  // Undefined encodings fall back to a full word access.
  function automatic logic [2:0] req_size(input logic [2:0] t);
    case (t)
      REQ_BYTE: return SIZE_1B;
      REQ_HALF: return SIZE_2B;
      default:  return SIZE_4B;
    endcase
  endfunction

endpackage

// File: rtl/axi_wr_channel.sv
// rtl/axi_wr_channel.sv - write FSM driving AXI AW/W/B with a 4-beat line data mux
module axi_wr_channel
  import dcache_bus_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic         wr_done,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic         awvalid,
  input  logic         awready,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic         bvalid,
  output logic         bready
);

  w_state_e     w_state_q;
  logic         awvalid_q, wvalid_q, bready_q, wr_done_q, line_q;
  logic [31:0]  awaddr_q;
  logic [7:0]   awlen_q;
  logic [2:0]   awsize_q;
  logic [3:0]   wstrb_q;
  logic [127:0] data_q;
  logic [1:0]   beat_q;
  logic         aw_fin, w_fin;

  assign wr_rdy  = (w_state_q == W_IDLE);
  assign wr_done = wr_done_q;
  assign awaddr  = awaddr_q;
  assign awlen   = awlen_q;
  assign awsize  = awsize_q;
  assign awvalid = awvalid_q;
  assign wvalid  = wvalid_q;
  assign wstrb   = wstrb_q;
  assign bready  = bready_q;
  assign wlast   = !line_q || (beat_q == 2'(LINE_BEATS - 1));

  always_comb begin
    wdata = data_q[31:0];
    case (beat_q)
      2'd1:    wdata = data_q[63:32];
      2'd2:    wdata = data_q[95:64];
      2'd3:    wdata = data_q[127:96];
      default: wdata = data_q[31:0];
    endcase
  end

  // AW and W retire independently; a channel counts as finished once its valid has dropped.
  assign aw_fin = !awvalid_q || awready;
  assign w_fin  = !wvalid_q || (wready && wlast);

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      wr_done_q <= 1'b0;
      line_q    <= 1'b0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      awsize_q  <= '0;
      wstrb_q   <= '0;
      data_q    <= '0;
      beat_q    <= '0;
    end else begin
      wr_done_q <= 1'b0;
      case (w_state_q)
        W_IDLE: begin
          if (wr_req) begin
            w_state_q <= W_XFER;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            beat_q    <= '0;
            data_q    <= wr_data;
            line_q    <= is_line(wr_type);
            if (is_line(wr_type)) begin
              awaddr_q <= {wr_addr[31:4], 4'b0};
              awlen_q  <= LINE_LEN;
              awsize_q <= SIZE_4B;
              wstrb_q  <= 4'hF;
            end else begin
              awaddr_q <= wr_addr;
              awlen_q  <= 8'd0;
              awsize_q <= req_size(wr_type);
              wstrb_q  <= wr_wstrb;
            end
          end
        end
        W_XFER: begin
          if (awvalid_q && awready) awvalid_q <= 1'b0;
          if (wvalid_q && wready) begin
            if (wlast) wvalid_q <= 1'b0;
            else       beat_q   <= beat_q + 2'd1;
          end
          if (aw_fin && w_fin) begin
            w_state_q <= W_RESP;
            bready_q  <= 1'b1;
          end
        end
        W_RESP: begin
          if (bvalid) begin
            w_state_q <= W_IDLE;
            bready_q  <= 1'b0;
            wr_done_q <= 1'b1;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/dcache_axi_bridge.sv
// rtl/dcache_axi_bridge.sv - dcache rd/wr request to AXI4 master bridge with independent read/write FSMs
// Optional DCACHE_BRIDGE_RAW_CHECK_EN: stall reads that hit the line of an in-flight write.
module dcache_axi_bridge
  import dcache_bus_pkg::*;
#(
  parameter int AXI_ID_W = 4,
  parameter int RD_ID    = 0,
  parameter int WR_ID    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_req,
  input  logic [2:0]          rd_type,
  input  logic [31:0]         rd_addr,
  output logic                rd_rdy,
  output logic                ret_valid,
  output logic                ret_last,
  output logic [31:0]         ret_data,
  input  logic                wr_req,
  input  logic [2:0]          wr_type,
  input  logic [31:0]         wr_addr,
  input  logic [3:0]          wr_wstrb,
  input  logic [127:0]        wr_data,
  output logic                wr_rdy,
  output logic                wr_done,
  output logic [AXI_ID_W-1:0] arid,
  output logic [31:0]         araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,
  input  logic [AXI_ID_W-1:0] rid,
  input  logic [31:0]         rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [AXI_ID_W-1:0] awid,
  output logic [31:0]         awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  output logic [31:0]         wdata,
  output logic [3:0]          wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [AXI_ID_W-1:0] bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  r_state_e    r_state_q;
  logic        arvalid_q, rready_q;
  logic [31:0] araddr_q;
  logic [7:0]  arlen_q;
  logic [2:0]  arsize_q;
  logic        rd_stall;
  logic        unused_ok;

  assign unused_ok = ^{rid, rresp, bid, bresp};

  assign arid    = AXI_ID_W'(RD_ID);
  assign awid    = AXI_ID_W'(WR_ID);
  assign arburst = BURST_INCR;
  assign awburst = BURST_INCR;
  assign arvalid = arvalid_q;
  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign arsize  = arsize_q;
  assign rready  = rready_q;

`ifdef DCACHE_BRIDGE_RAW_CHECK_EN
  // awaddr[31:4] is the line of the pending write for both line and sub-word writes.
  assign rd_stall = !wr_rdy && (awaddr[31:4] == rd_addr[31:4]);
`else
  assign rd_stall = 1'b0;
`endif

  assign rd_rdy    = (r_state_q == R_IDLE) && !rd_stall;
  assign ret_valid = rvalid && (r_state_q == R_DATA);
  assign ret_last  = rlast;
  assign ret_data  = rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (rd_req && rd_rdy) begin
            r_state_q <= R_AR;
            arvalid_q <= 1'b1;
            if (is_line(rd_type)) begin
              araddr_q <= {rd_addr[31:4], 4'b0};
              arlen_q  <= LINE_LEN;
              arsize_q <= SIZE_4B;
            end else begin
              araddr_q <= rd_addr;
              arlen_q  <= 8'd0;
              arsize_q <= req_size(rd_type);
            end
          end
        end
        R_AR: begin
          if (arready) begin
            r_state_q <= R_DATA;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        R_DATA: begin
          if (rvalid && rlast) begin
            r_state_q <= R_IDLE;
            rready_q  <= 1'b0;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  axi_wr_channel u_wr (
    .clk      (clk),
    .rst      (rst),
    .wr_req   (wr_req),
    .wr_type  (wr_type),
    .wr_addr  (wr_addr),
    .wr_wstrb (wr_wstrb),
    .wr_data  (wr_data),
    .wr_rdy   (wr_rdy),
    .wr_done  (wr_done),
    .awaddr   (awaddr),
    .awlen    (awlen),
    .awsize   (awsize),
    .awvalid  (awvalid),
    .awready  (awready),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wlast    (wlast),
    .wvalid   (wvalid),
    .wready   (wready),
    .bvalid   (bvalid),
    .bready   (bready)
  );

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// tb/tb_dcache_axi_bridge.sv - directed self-checking bench for dcache_axi_bridge
module tb_dcache_axi_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy, ret_valid, ret_last;
  logic [31:0]  ret_data;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy, wr_done;
  logic [3:0]   arid, rid, awid, bid;
  logic [31:0]  araddr, rdata, awaddr, wdata;
  logic [7:0]   arlen, awlen;
  logic [2:0]   arsize, awsize;
  logic [1:0]   arburst, rresp, awburst, bresp;
  logic         arvalid, arready, rlast, rvalid, rready;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]   wstrb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dcache_axi_bridge #(.AXI_ID_W(4), .RD_ID(0), .WR_ID(1)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy), .wr_done(wr_done),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL rst_arvalid got %0h exp 0", arvalid); end
    checks++; if (awvalid !== 1'b0) begin errors++; $display("FAIL rst_awvalid got %0h exp 0", awvalid); end
    checks++; if (wvalid !== 1'b0) begin errors++; $display("FAIL rst_wvalid got %0h exp 0", wvalid); end
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL rst_rready got %0h exp 0", rready); end
    checks++; if (bready !== 1'b0) begin errors++; $display("FAIL rst_bready got %0h exp 0", bready); end
    checks++; if (wr_done !== 1'b0) begin errors++; $display("FAIL rst_wr_done got %0h exp 0", wr_done); end
    checks++; if (ret_valid !== 1'b0) begin errors++; $display("FAIL rst_ret_valid got %0h exp 0", ret_valid); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (rd_rdy !== 1'b1) begin errors++; $display("FAIL rst_rd_rdy got %0h exp 1", rd_rdy); end
    checks++; if (wr_rdy !== 1'b1) begin errors++; $display("FAIL rst_wr_rdy got %0h exp 1", wr_rdy); end
  endtask

  task automatic test_word_read();
    rd_req = 1'b1; rd_type = 3'b010; rd_addr = 32'h1000_0004; arready = 1'b1;
    #1;
    checks++; if (rd_rdy !== 1'b1) begin errors++; $display("FAIL wrd_rd_rdy got %0h exp 1", rd_rdy); end
    @(negedge clk);
    rd_req = 1'b0;
    checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL wrd_arvalid got %0h exp 1", arvalid); end
    checks++; if (araddr !== 32'h1000_0004) begin errors++; $display("FAIL wrd_araddr got %h exp 10000004", araddr); end
    checks++; if (arlen !== 8'd0) begin errors++; $display("FAIL wrd_arlen got %0d exp 0", arlen); end
    checks++; if (arsize !== 3'd2) begin errors++; $display("FAIL wrd_arsize got %0d exp 2", arsize); end
    checks++; if (arburst !== 2'b01) begin errors++; $display("FAIL wrd_arburst got %0d exp 1", arburst); end
    checks++; if (arid !== 4'd0) begin errors++; $display("FAIL wrd_arid got %0d exp 0", arid); end
    checks++; if (rd_rdy !== 1'b0) begin errors++; $display("FAIL wrd_rd_rdy_busy got %0h exp 0", rd_rdy); end
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'hCAFE_0004;
    #1;
    checks++; if (ret_valid !== 1'b0) begin errors++; $display("FAIL wrd_ret_early got %0h exp 0", ret_valid); end
    @(negedge clk);
    checks++; if (ret_valid !== 1'b1) begin errors++; $display("FAIL wrd_ret_valid got %0h exp 1", ret_valid); end
    checks++; if (ret_last !== 1'b1) begin errors++; $display("FAIL wrd_ret_last got %0h exp 1", ret_last); end
    checks++; if (ret_data !== 32'hCAFE_0004) begin errors++; $display("FAIL wrd_ret_data got %h exp cafe0004", ret_data); end
    checks++; if (rready !== 1'b1) begin errors++; $display("FAIL wrd_rready got %0h exp 1", rready); end
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL wrd_arvalid_drop got %0h exp 0", arvalid); end
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0; arready = 1'b0;
    checks++; if (rd_rdy !== 1'b1) begin errors++; $display("FAIL wrd_rd_rdy_end got %0h exp 1", rd_rdy); end
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL wrd_rready_end got %0h exp 0", rready); end
  endtask

  task automatic test_line_read();
    rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h1000_0028; arready = 1'b0;
    @(negedge clk);
    rd_req = 1'b0; rd_addr = 32'hFFFF_FFFF;
    checks++; if (araddr !== 32'h1000_0020) begin errors++; $display("FAIL lrd_araddr got %h exp 10000020", araddr); end
    checks++; if (arlen !== 8'd3) begin errors++; $display("FAIL lrd_arlen got %0d exp 3", arlen); end
    checks++; if (arsize !== 3'd2) begin errors++; $display("FAIL lrd_arsize got %0d exp 2", arsize); end
    @(negedge clk);
    checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL lrd_arvalid_hold got %0h exp 1", arvalid); end
    checks++; if (araddr !== 32'h1000_0020) begin errors++; $display("FAIL lrd_araddr_hold got %h exp 10000020", araddr); end
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL lrd_arvalid_drop got %0h exp 0", arvalid); end
    checks++; if (rready !== 1'b1) begin errors++; $display("FAIL lrd_rready got %0h exp 1", rready); end
    for (int i = 0; i < 4; i++) begin
      rvalid = 1'b0; rlast = 1'b0;
      #1;
      checks++; if (ret_valid !== 1'b0) begin errors++; $display("FAIL lrd_gap%0d got %0h exp 0", i, ret_valid); end
      @(negedge clk);
      rvalid = 1'b1; rlast = (i == 3); rdata = 32'hD000_0000 + i;
      #1;
      checks++; if (ret_valid !== 1'b1) begin errors++; $display("FAIL lrd_beat%0d_valid got %0h exp 1", i, ret_valid); end
      checks++; if (ret_last !== (i == 3)) begin errors++; $display("FAIL lrd_beat%0d_last got %0h exp %0h", i, ret_last, (i == 3)); end
      checks++; if (ret_data !== 32'hD000_0000 + i) begin errors++; $display("FAIL lrd_beat%0d_data got %h exp %h", i, ret_data, 32'hD000_0000 + i); end
      @(negedge clk);
    end
    rvalid = 1'b0; rlast = 1'b0;
    checks++; if (rd_rdy !== 1'b1) begin errors++; $display("FAIL lrd_rd_rdy_end got %0h exp 1", rd_rdy); end
  endtask

  task automatic test_read_types();
    logic [2:0] types [4];
    logic [2:0] sizes [4];
    types = '{3'b001, 3'b011, 3'b111, 3'b000};
    sizes = '{3'd1, 3'd2, 3'd2, 3'd0};
    for (int i = 0; i < 4; i++) begin
      rd_req = 1'b1; rd_type = types[i]; rd_addr = 32'h5000_0006; arready = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
      checks++; if (arsize !== sizes[i]) begin errors++; $display("FAIL typ%0d_arsize got %0d exp %0d", i, arsize, sizes[i]); end
      checks++; if (arlen !== 8'd0) begin errors++; $display("FAIL typ%0d_arlen got %0d exp 0", i, arlen); end
      checks++; if (araddr !== 32'h5000_0006) begin errors++; $display("FAIL typ%0d_araddr got %h exp 50000006", i, araddr); end
      rvalid = 1'b1; rlast = 1'b1; rdata = 32'h0;
      @(negedge clk);
      @(negedge clk);
      rvalid = 1'b0; rlast = 1'b0; arready = 1'b0;
    end
  endtask

  task automatic test_byte_write();
    wr_req = 1'b1; wr_type = 3'b000; wr_addr = 32'h2000_0003; wr_wstrb = 4'b1000;
    wr_data = {96'h0, 32'hAABB_CCDD}; awready = 1'b1; wready = 1'b1;
    @(negedge clk);
    wr_req = 1'b0;
    checks++; if (awvalid !== 1'b1) begin errors++; $display("FAIL bw_awvalid got %0h exp 1", awvalid); end
    checks++; if (wvalid !== 1'b1) begin errors++; $display("FAIL bw_wvalid got %0h exp 1", wvalid); end
    checks++; if (awaddr !== 32'h2000_0003) begin errors++; $display("FAIL bw_awaddr got %h exp 20000003", awaddr); end
    checks++; if (awsize !== 3'd0) begin errors++; $display("FAIL bw_awsize got %0d exp 0", awsize); end
    checks++; if (awlen !== 8'd0) begin errors++; $display("FAIL bw_awlen got %0d exp 0", awlen); end
    checks++; if (wlast !== 1'b1) begin errors++; $display("FAIL bw_wlast got %0h exp 1", wlast); end
    checks++; if (wstrb !== 4'b1000) begin errors++; $display("FAIL bw_wstrb got %b exp 1000", wstrb); end
    checks++; if (wdata !== 32'hAABB_CCDD) begin errors++; $display("FAIL bw_wdata got %h exp aabbccdd", wdata); end
    checks++; if (awid !== 4'd1) begin errors++; $display("FAIL bw_awid got %0d exp 1", awid); end
    checks++; if (wr_rdy !== 1'b0) begin errors++; $display("FAIL bw_wr_rdy got %0h exp 0", wr_rdy); end
    @(negedge clk);
    awready = 1'b0; wready = 1'b0;
    checks++; if (awvalid !== 1'b0 || wvalid !== 1'b0) begin errors++; $display("FAIL bw_valid_drop got aw=%0h w=%0h exp 0 0", awvalid, wvalid); end
    checks++; if (bready !== 1'b1) begin errors++; $display("FAIL bw_bready got %0h exp 1", bready); end
    checks++; if (wr_done !== 1'b0) begin errors++; $display("FAIL bw_done_early got %0h exp 0", wr_done); end
    bvalid = 1'b1;
    @(negedge clk);
    bvalid = 1'b0;
    checks++; if (wr_done !== 1'b1) begin errors++; $display("FAIL bw_wr_done got %0h exp 1", wr_done); end
    checks++; if (wr_rdy !== 1'b1) begin errors++; $display("FAIL bw_wr_rdy_end got %0h exp 1", wr_rdy); end
    checks++; if (bready !== 1'b0) begin errors++; $display("FAIL bw_bready_end got %0h exp 0", bready); end
    @(negedge clk);
    checks++; if (wr_done !== 1'b0) begin errors++; $display("FAIL bw_done_pulse got %0h exp 0", wr_done); end
  endtask

  task automatic test_line_write();
    logic [31:0] exp_w [4];
    exp_w = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h3000_0018; wr_wstrb = 4'b0001;
    wr_data = 128'h4444_4444_3333_3333_2222_2222_1111_1111; awready = 1'b0; wready = 1'b1;
    @(negedge clk);
    wr_req = 1'b0; wr_data = '0;
    checks++; if (awaddr !== 32'h3000_0010) begin errors++; $display("FAIL lw_awaddr got %h exp 30000010", awaddr); end
    checks++; if (awlen !== 8'd3) begin errors++; $display("FAIL lw_awlen got %0d exp 3", awlen); end
    checks++; if (awsize !== 3'd2) begin errors++; $display("FAIL lw_awsize got %0d exp 2", awsize); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (wvalid !== 1'b1) begin errors++; $display("FAIL lw_beat%0d_wvalid got %0h exp 1", i, wvalid); end
      checks++; if (wdata !== exp_w[i]) begin errors++; $display("FAIL lw_beat%0d_wdata got %h exp %h", i, wdata, exp_w[i]); end
      checks++; if (wlast !== (i == 3)) begin errors++; $display("FAIL lw_beat%0d_wlast got %0h exp %0h", i, wlast, (i == 3)); end
      checks++; if (wstrb !== 4'hF) begin errors++; $display("FAIL lw_beat%0d_wstrb got %h exp f", i, wstrb); end
      checks++; if (awvalid !== 1'b1) begin errors++; $display("FAIL lw_beat%0d_awvalid got %0h exp 1", i, awvalid); end
      checks++; if (wr_rdy !== 1'b0) begin errors++; $display("FAIL lw_beat%0d_wr_rdy got %0h exp 0", i, wr_rdy); end
      if (i == 3) awready = 1'b1;
      @(negedge clk);
    end
    awready = 1'b0; wready = 1'b0;
    checks++; if (awvalid !== 1'b0 || wvalid !== 1'b0) begin errors++; $display("FAIL lw_valid_drop got aw=%0h w=%0h exp 0 0", awvalid, wvalid); end
    checks++; if (bready !== 1'b1) begin errors++; $display("FAIL lw_bready got %0h exp 1", bready); end
    checks++; if (wr_rdy !== 1'b0) begin errors++; $display("FAIL lw_wr_rdy_resp got %0h exp 0", wr_rdy); end
    @(negedge clk);
    bvalid = 1'b1;
    @(negedge clk);
    bvalid = 1'b0;
    checks++; if (wr_done !== 1'b1) begin errors++; $display("FAIL lw_wr_done got %0h exp 1", wr_done); end
    checks++; if (wr_rdy !== 1'b1) begin errors++; $display("FAIL lw_wr_rdy_end got %0h exp 1", wr_rdy); end
  endtask

  task automatic test_aw_first();
    wr_req = 1'b1; wr_type = 3'b010; wr_addr = 32'h6000_0008; wr_wstrb = 4'hF;
    wr_data = {96'h0, 32'h0BAD_F00D}; awready = 1'b1; wready = 1'b0;
    @(negedge clk);
    wr_req = 1'b0;
    checks++; if (awsize !== 3'd2) begin errors++; $display("FAIL awf_awsize got %0d exp 2", awsize); end
    @(negedge clk);
    awready = 1'b0;
    checks++; if (awvalid !== 1'b0) begin errors++; $display("FAIL awf_awvalid got %0h exp 0", awvalid); end
    checks++; if (wvalid !== 1'b1) begin errors++; $display("FAIL awf_wvalid got %0h exp 1", wvalid); end
    checks++; if (bready !== 1'b0) begin errors++; $display("FAIL awf_bready_early got %0h exp 0", bready); end
    @(negedge clk);
    checks++; if (wvalid !== 1'b1) begin errors++; $display("FAIL awf_wvalid_hold got %0h exp 1", wvalid); end
    wready = 1'b1;
    @(negedge clk);
    wready = 1'b0;
    checks++; if (bready !== 1'b1) begin errors++; $display("FAIL awf_bready got %0h exp 1", bready); end
    bvalid = 1'b1;
    @(negedge clk);
    bvalid = 1'b0;
    checks++; if (wr_done !== 1'b1) begin errors++; $display("FAIL awf_wr_done got %0h exp 1", wr_done); end
  endtask

  task automatic test_concurrent();
    logic exp_rdy;
`ifdef DCACHE_BRIDGE_RAW_CHECK_EN
    exp_rdy = 1'b0;
`else
    exp_rdy = 1'b1;
`endif
    rd_req = 1'b1; rd_type = 3'b010; rd_addr = 32'h4000_0004; arready = 1'b1;
    wr_req = 1'b1; wr_type = 3'b010; wr_addr = 32'h4000_0008; wr_wstrb = 4'hF;
    wr_data = {96'h0, 32'h5555_5555}; awready = 1'b0; wready = 1'b0;
    #1;
    checks++; if (rd_rdy !== 1'b1 || wr_rdy !== 1'b1) begin errors++; $display("FAIL cc_accept got rd=%0h wr=%0h exp 1 1", rd_rdy, wr_rdy); end
    @(negedge clk);
    rd_req = 1'b0; wr_req = 1'b0;
    checks++; if (arvalid !== 1'b1 || awvalid !== 1'b1 || wvalid !== 1'b1) begin errors++; $display("FAIL cc_valids got ar=%0h aw=%0h w=%0h exp 1 1 1", arvalid, awvalid, wvalid); end
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'h7777_0004;
    @(negedge clk);
    arready = 1'b0;
    checks++; if (ret_valid !== 1'b1) begin errors++; $display("FAIL cc_ret_valid got %0h exp 1", ret_valid); end
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0;
    checks++; if (rd_rdy !== exp_rdy) begin errors++; $display("FAIL cc_raw_rdy got %0h exp %0h", rd_rdy, exp_rdy); end
    awready = 1'b1; wready = 1'b1;
    @(negedge clk);
    awready = 1'b0; wready = 1'b0;
    checks++; if (bready !== 1'b1) begin errors++; $display("FAIL cc_bready got %0h exp 1", bready); end
    checks++; if (rd_rdy !== exp_rdy) begin errors++; $display("FAIL cc_raw_rdy_resp got %0h exp %0h", rd_rdy, exp_rdy); end
    bvalid = 1'b1;
    @(negedge clk);
    bvalid = 1'b0;
    checks++; if (wr_done !== 1'b1) begin errors++; $display("FAIL cc_wr_done got %0h exp 1", wr_done); end
    checks++; if (rd_rdy !== 1'b1) begin errors++; $display("FAIL cc_rd_rdy_end got %0h exp 1", rd_rdy); end
  endtask

  task automatic test_reset_mid_read();
    rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h7000_0040; arready = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    @(negedge clk);
    arready = 1'b0;
    rvalid = 1'b1; rlast = 1'b0; rdata = 32'h1;
    @(negedge clk);
    rvalid = 1'b0;
    checks++; if (rready !== 1'b1) begin errors++; $display("FAIL rmr_rready_pre got %0h exp 1", rready); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL rmr_arvalid got %0h exp 0", arvalid); end
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL rmr_rready got %0h exp 0", rready); end
    checks++; if (rd_rdy !== 1'b1) begin errors++; $display("FAIL rmr_rd_rdy got %0h exp 1", rd_rdy); end
  endtask

  initial begin
    rst = 1'b1;
    rd_req = 1'b0; rd_type = 3'b0; rd_addr = '0;
    wr_req = 1'b0; wr_type = 3'b0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
    test_reset();
    test_word_read();
    test_line_read();
    test_read_types();
    test_byte_write();
    test_line_write();
    test_aw_first();
    test_concurrent();
    test_reset_mid_read();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
